mat_vec_mult: RTL

Sequential signed matrix–vector multiplier that consumes the `SIZE_A`×`SIZE_B` signed 22-bit matrix produced by the matrix-load stage and multiplies it by a `SIZE_B`-element vector. It uses one multiply-accumulate per clock and emits one fixed-point 22-bit result per row over a valid/ready handshake. The block sits directly downstream of the matrix source in the fetal-ECG separation datapath, where it applies weight/whitening matrices to sample vectors.

---
 rtl/mat_vec_mult.sv | 116 +++++++++++
 1 files changed

// File: rtl/mat_vec_mult.sv
// rtl/mat_vec_mult.sv - sequential signed matrix-vector multiplier, one MAC per clock
// Optional output clamping to the 22-bit range when MAT_VEC_SATURATE_EN is defined.
module mat_vec_mult #(
    parameter int SIZE_A    = 8,
    parameter int SIZE_B    = 8,
    parameter int FRAC_BITS = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic signed [21:0]                in_matrix [SIZE_A][SIZE_B],
    input  logic signed [21:0]                in_vector [SIZE_B],
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              out_valid,
    output logic [$clog2(SIZE_A)-1:0]         out_row,
    output logic signed [21:0]                out_data,
    output logic                              done
);
    localparam int RW    = $clog2(SIZE_A);
    localparam int CW    = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int ACC_W = 44 + $clog2(SIZE_B);
    localparam logic [RW-1:0] LAST_ROW = RW'(SIZE_A - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(SIZE_B - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

    state_t                   state;
    logic [RW-1:0]            row;
    logic [CW-1:0]            col;
    logic signed [ACC_W-1:0]  acc;
    logic signed [43:0]       prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [21:0]       result;

`ifdef MAT_VEC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2097151);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-2097152);
`endif

    // The result register is loaded from the final sum on the last MAC cycle,
    // so a row is presented one cycle after its last product.
    always_comb begin
        prod     = in_matrix[row][col] * in_vector[col];
        acc_next = acc + ACC_W'(prod);
        shifted  = acc_next >>> FRAC_BITS;
`ifdef MAT_VEC_SATURATE_EN
        if (shifted > SAT_MAX)
            result = 22'h1FFFFF;
        else if (shifted < SAT_MIN)
            result = 22'h200000;
        else
            result = 22'(shifted);
`else
        result = 22'(shifted);
`endif
    end

    assign out_row = row;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= MAC;
                        busy  <= 1'b1;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    col <= col + 1'b1;
                    if (col == LAST_COL) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= result;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (row == LAST_ROW) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= MAC;
                            row   <= row + 1'b1;
                            col   <= '0;
                            acc   <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
